// File: rtl/prng_seq.sv
// prng_seq: start/done initiator for the Lehmer prng core. Chains each result
// back as the next seed and buffers results in a FIFO behind a valid/ready port.
`default_nettype none

module prng_seq #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     seed_load,
    input  logic [WIDTH-1:0]         seed_in,
    input  logic                     flush,
    output logic                     prng_start,
    output logic [WIDTH-1:0]         prng_seed,
    input  logic                     prng_done,
    input  logic [WIDTH-1:0]         prng_rand,
    output logic [WIDTH-1:0]         rnd_data,
    output logic                     rnd_valid,
    input  logic                     rnd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  seed_q, seed_d;
    logic              pend_q, pend_d;
    logic [WIDTH-1:0]  pend_seed_q, pend_seed_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              to_idle;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     wr_q, rd_q;
    logic [LW-1:0]     cnt_q;
    logic              push, pop;
    logic [PW-1:0]     wr_idx;

    assign push   = (state_q == S_REQ) && prng_done;
    assign pop    = rnd_valid && rnd_ready;
    assign wr_idx = flush ? {PW{1'b0}} : wr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            seed_q      <= WIDTH'(1);
            pend_q      <= 1'b0;
            pend_seed_q <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            pend_q      <= pend_d;
            pend_seed_q <= pend_seed_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        pend_d      = pend_q;
        pend_seed_d = pend_seed_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        to_idle     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (seed_load) seed_d = seed_in;
                // Only one request is ever in flight, so free space here is the reservation.
                if (run && !err_q && (cnt_q < DEPTH_L)) begin
                    state_d = S_REQ;
                    tmo_d   = '0;
                end
            end
            S_REQ: begin
                if (prng_done) begin
                    seed_d  = prng_rand;
                    state_d = S_ACK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    to_idle = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_ACK: begin
                if (!prng_done) begin
                    state_d = S_IDLE;
                    to_idle = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (seed_load && (state_q != S_IDLE)) begin
            pend_d      = 1'b1;
            pend_seed_d = seed_in;
        end
        // A deferred load wins over the chained result once the handshake is over.
        if (to_idle && pend_d) begin
            seed_d = pend_seed_d;
            pend_d = 1'b0;
        end
        if (seed_load) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) mem_q[wr_idx] <= prng_rand;
            if (flush) begin
                rd_q  <= '0;
                wr_q  <= push ? PW'(1) : '0;
                cnt_q <= push ? LW'(1) : '0;
            end else begin
                if (push) wr_q <= wr_q + PW'(1);
                if (pop)  rd_q <= rd_q + PW'(1);
                if (push && !pop)      cnt_q <= cnt_q + LW'(1);
                else if (pop && !push) cnt_q <= cnt_q - LW'(1);
            end
        end
    end

    assign prng_start = (state_q == S_REQ);
    assign prng_seed  = seed_q;
    assign rnd_valid  = (cnt_q != '0);
    assign rnd_data   = rnd_valid ? mem_q[rd_q] : '0;
    assign level      = cnt_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: doc/prng_seq.md
Name: prng_seq

Overview:
- Initiator for the prng core's start/done four-phase handshake.
- Drives seeds into the core, collects each `rand` result and chains it back as the next seed, so the core walks a Lehmer sequence (a=16807, m=2^31-1 in the core).
- Buffers results in a small FIFO behind a valid/ready stream port for downstream consumers.
- Sits between the prng core and any block that needs a steady supply of random words.

Parameters:
- WIDTH, 32, data width of seed and result.
- DEPTH, 4, FIFO entries; power of two, >=2.
- TIMEOUT, 64, max cycles in REQ waiting for prng_done before aborting.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  level; 1 = keep issuing requests while FIFO has room.
- seed_load  in  1  one-cycle pulse; load seed_in as next seed.
- seed_in  in  WIDTH  seed value sampled with seed_load.
- flush  in  1  one-cycle pulse; empties FIFO.
- prng_start  out  1  to core `start`.
- prng_seed  out  WIDTH  to core `seed`; stable while prng_start=1.
- prng_done  in  1  from core `done`.
- prng_rand  in  WIDTH  from core `rand`; valid while prng_done=1.
- rnd_data  out  WIDTH  FIFO head.
- rnd_valid  out  1  FIFO non-empty.
- rnd_ready  in  1  consumer accept; pop when rnd_valid & rnd_ready.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; prng_start=0; prng_seed=1.
  - FIFO empty: rnd_valid=0, rnd_data=0, level=0.
  - err=0; pending-load flag cleared.
- States:
  - IDLE: issue a request when run=1 & err=0 & level + in_flight < DEPTH (in_flight=0 in IDLE). prng_start<=1 next cycle; go to REQ; clear the timeout counter.
  - REQ: prng_start=1; prng_seed held constant.
    - When prng_done=1: push prng_rand into FIFO, copy prng_rand into the seed register, drop prng_start, go to ACK.
    - If the counter reaches TIMEOUT first: drop prng_start, set err=1, go to IDLE, seed unchanged.
  - ACK: prng_start=0; wait for prng_done=0, then go to IDLE. A new request is never raised before done has fallen.
- Handshake rules:
  - Exactly one FIFO push per completed handshake.
  - prng_done=1 seen in IDLE or ACK is ignored; no push.
- Space reservation: a request is only raised when the FIFO can accept its result, so a push never hits a full FIFO.
- seed_load:
  - In IDLE: the seed register takes seed_in on the next edge, overriding chaining.
  - In REQ or ACK: stored as pending; applied on entry to IDLE, overriding the chained value.
  - Always clears err.
  - A second load before application overwrites the pending value.
- FIFO:
  - Registered head; push and pop in the same cycle leave level unchanged.
  - Pop when empty is ignored.
- flush:
  - Clears FIFO and level next cycle and takes priority over a same-cycle pop.
  - A push in the same cycle as flush is kept, giving level=1 after.
  - Does not touch the handshake FSM.
- run dropped mid-handshake: the current handshake completes and its result is pushed; no new request follows.
- Latency: result appears on rnd_valid 1 cycle after the capture edge in REQ.
- level range is 0..DEPTH.
- Wrap-around: FIFO pointers wrap modulo DEPTH.

Test Plan:
- Reset, seed_load seed_in=0x7B818935, run=1, behavioural core (a=16807, m=2^31-1, 3-cycle latency) -> first rnd_data=0x755735EB. The second request carries prng_seed=0x755735EB.
- rnd_ready=0, run=1 -> exactly DEPTH=4 handshakes, then prng_start stays 0 and level=4. Assert rnd_ready for one cycle -> level=3, then one new handshake -> level=4.
- Core model never asserts done -> prng_start falls after 64 cycles, err=1, no further requests. seed_load -> err=0 and requests resume.
- seed_load=0x142E4ECE while in REQ -> the in-flight result is still pushed. The next request uses prng_seed=0x142E4ECE, not the chained value.
- Assert rst=0 mid-REQ, asynchronously -> prng_start=0, level=0, rnd_valid=0, err=0 immediately. The core model returns done, which is ignored.
- FIFO holds 2 entries; flush in the same cycle as a push -> level=1, rnd_data equals the newly pushed value.
